// File: rtl/mmio_mailbox.sv
// -----------------------------------------------------------------------------
// mmio_mailbox
//
// Memory-mapped mailbox on the processor data-memory bus. Software sees two
// word FIFOs in a 16-byte window at BASE_ADDR:
//   0x0 TXDATA  (W)   store pushes a word toward the external host
//   0x4 RXDATA  (R)   load returns/pops the oldest word from the host
//   0x8 STATUS  (R/W1C) full/empty flags, sticky tx_ovf/rx_udf, occupancies
//   0xC CTRL    (R/W) interrupt enables, only when MBOX_IRQ_EN is defined
//
// Build option: define MBOX_IRQ_EN to enable CTRL and the registered irq
// output; otherwise CTRL reads 0 and irq is tied low.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   addr, wd, we, re  CPU byte address, store data, store/load strobes
//   rd, sel           combinational load data, window-select decode
//   tx_data/valid/ready  TX stream toward host (valid/ready)
//   rx_data/valid/ready  RX stream from host (valid/ready)
//   irq               interrupt request
// -----------------------------------------------------------------------------
module mmio_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rd,
    output logic        sel,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Occupancy as an 8-bit STATUS field (zero-extend or truncate).
    function automatic logic [7:0] cnt8(input logic [CW-1:0] c);
        cnt8 = 8'(c);
    endfunction

    logic [31:0]   tx_mem_q [DEPTH];
    logic [31:0]   rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;

    logic          tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic          wr_tx_s, rd_rx_s, wr_st_s;
    logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic [31:0]   status_s, ctrl_rd_s;
    logic          unused_s;

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign unused_s   = ^addr[1:0];

    assign tx_full_s  = (tx_cnt_q == CNT_FULL);
    assign tx_empty_s = (tx_cnt_q == CNT_ZERO);
    assign rx_full_s  = (rx_cnt_q == CNT_FULL);
    assign rx_empty_s = (rx_cnt_q == CNT_ZERO);

    assign wr_tx_s    = we & sel & (addr[3:2] == 2'd0);
    assign rd_rx_s    = re & sel & (addr[3:2] == 2'd1);
    assign wr_st_s    = we & sel & (addr[3:2] == 2'd2);

    // Fullness/emptiness are pre-edge values: a same-cycle pop never rescues
    // a push into a full FIFO.
    assign tx_push_s  = wr_tx_s & ~tx_full_s;
    assign tx_pop_s   = ~tx_empty_s & tx_ready;
    assign rx_push_s  = rx_valid & ~rx_full_s;
    assign rx_pop_s   = rd_rx_s & ~rx_empty_s;

    assign tx_valid   = ~tx_empty_s;
    assign tx_data    = tx_mem_q[tx_rp_q];
    assign rx_ready   = ~rx_full_s;

    assign status_s   = {8'd0, cnt8(rx_cnt_q), cnt8(tx_cnt_q), 2'b00,
                         rx_udf_q, tx_ovf_q, rx_empty_s, rx_full_s,
                         tx_empty_s, tx_full_s};

    // Next-state for pointers, counts and sticky flags (set beats W1C).
    always_comb begin
        tx_wp_d = tx_push_s ? (tx_wp_q + PTR_ONE) : tx_wp_q;
        tx_rp_d = tx_pop_s  ? (tx_rp_q + PTR_ONE) : tx_rp_q;
        rx_wp_d = rx_push_s ? (rx_wp_q + PTR_ONE) : rx_wp_q;
        rx_rp_d = rx_pop_s  ? (rx_rp_q + PTR_ONE) : rx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        tx_ovf_d = (wr_tx_s & tx_full_s)  | (tx_ovf_q & ~(wr_st_s & wd[4]));
        rx_udf_d = (rd_rx_s & rx_empty_s) | (rx_udf_q & ~(wr_st_s & wd[5]));
    end

    // FIFO control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
        end
    end

    // Storage arrays; contents are meaningless until a pointer covers them.
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wp_q] <= wd;
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wp_q] <= rx_data;
        end
    end

`ifdef MBOX_IRQ_EN
    logic [2:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;
    logic       wr_ctrl_s;

    assign wr_ctrl_s = we & sel & (addr[3:2] == 2'd3);

    // CTRL write and irq condition from the current registered state.
    always_comb begin
        ctrl_d = wr_ctrl_s ? wd[2:0] : ctrl_q;
        irq_d  = (ctrl_q[0] & ~rx_empty_s) |
                 (ctrl_q[1] & tx_empty_s)  |
                 (ctrl_q[2] & (tx_ovf_q | rx_udf_q));
    end

    // CTRL and registered irq.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q <= 3'b000;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign irq       = irq_q;
    assign ctrl_rd_s = {29'd0, ctrl_q};
`else
    assign irq       = 1'b0;
    assign ctrl_rd_s = 32'd0;
`endif

    // Load-data mux; depends on addr and FIFO state only.
    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (addr[3:2])
                2'd0:    rd = 32'd0;
                2'd1:    rd = rx_empty_s ? 32'd0 : rx_mem_q[rx_rp_q];
                2'd2:    rd = status_s;
                2'd3:    rd = ctrl_rd_s;
                default: rd = 32'd0;
            endcase
        end else begin
            rd = 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_mailbox.sv
module tb_mmio_mailbox;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wd, rd, tx_data, rx_data;
    logic        we, re, sel, tx_valid, tx_ready, rx_valid, rx_ready, irq;

    int total = 0;
    int bad   = 0;

    mmio_mailbox #(.BASE_ADDR(32'h0000_0800), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wd(wd), .we(we), .re(re),
        .rd(rd), .sel(sel), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        #1;
        d = rd;
        tick();
        re = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        peek(32'h0000_0808, v);
        total++; if (v !== 32'h0000_000A) begin bad++; $display("FAIL reset_status got=%h exp=0000000a", v); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        peek(32'h0000_0000, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_rd_addr0 got=%h exp=00000000", v); end
    endtask

    task automatic test_decode();
        logic [31:0] v;
        peek(32'h0000_0900, v);
        total++; if (sel !== 1'b0 || v !== 32'h0) begin bad++; $display("FAIL decode_outside sel=%b rd=%h exp sel=0 rd=0", sel, v); end
        peek(32'h0000_080B, v);
        total++; if (sel !== 1'b1 || v !== 32'h0000_000A) begin bad++; $display("FAIL decode_lowbits sel=%b rd=%h exp sel=1 rd=0000000a", sel, v); end
    endtask

    task automatic test_tx_stream();
        logic [31:0] v;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
        tx_ready = 1'b0;
        cpu_write(32'h0000_0800, exp_w[0]);
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL tx_latency got=%b exp=1", tx_valid); end
        cpu_write(32'h0000_0800, exp_w[1]);
        cpu_write(32'h0000_0800, exp_w[2]);
        peek(32'h0000_0808, v);
        total++; if (v[15:8] !== 8'd3) begin bad++; $display("FAIL tx_count got=%0d exp=3", v[15:8]); end
        peek(32'h0000_0800, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL txdata_reads0 got=%h exp=00000000", v); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== exp_w[i]) begin bad++; $display("FAIL tx_stream[%0d] valid=%b data=%h exp valid=1 data=%h", i, tx_valid, tx_data, exp_w[i]); end
            tick();
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        logic [31:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_write(32'h0000_0800, 32'hA0 + 32'(i));
        peek(32'h0000_0808, v);
        total++; if (v !== 32'h0000_0419) begin bad++; $display("FAIL tx_ovf_status got=%h exp=00000419", v); end
        total++; if (tx_data !== 32'hA0) begin bad++; $display("FAIL tx_ovf_head got=%h exp=000000a0", tx_data); end
        // Store while full with a same-cycle host pop: dropped anyway.
        tx_ready = 1'b1;
        cpu_write(32'h0000_0800, 32'hA5);
        peek(32'h0000_0808, v);
        total++; if (v[15:8] !== 8'd3 || v[4] !== 1'b1) begin bad++; $display("FAIL tx_full_pop cnt=%0d ovf=%b exp cnt=3 ovf=1", v[15:8], v[4]); end
        for (int i = 1; i < 4; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL tx_ovf_data[%0d] valid=%b data=%h exp=%h", i, tx_valid, tx_data, 32'hA0 + 32'(i)); end
            tick();
        end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_ovf_drained got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
        cpu_write(32'h0000_0808, 32'h10);
        peek(32'h0000_0808, v);
        total++; if (v !== 32'h0000_000A) begin bad++; $display("FAIL tx_ovf_w1c got=%h exp=0000000a", v); end
    endtask

    task automatic test_rx_backpressure();
        logic [31:0] v;
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 32'hB0 + 32'(i);
            total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready_fill[%0d] got=%b exp=1", i, rx_ready); end
            tick();
        end
        rx_data = 32'hB4;
        peek(32'h0000_0808, v);
        total++; if (rx_ready !== 1'b0 || v !== 32'h0004_0006) begin bad++; $display("FAIL rx_full ready=%b status=%h exp ready=0 status=00040006", rx_ready, v); end
        addr = 32'h0000_0804; re = 1'b1;
        #1;
        total++; if (rd !== 32'hB0 || rx_ready !== 1'b0) begin bad++; $display("FAIL rx_pop_full rd=%h ready=%b exp rd=000000b0 ready=0", rd, rx_ready); end
        tick();
        re = 1'b0;
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready_after_pop got=%b exp=1", rx_ready); end
        tick();
        rx_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            cpu_read(32'h0000_0804, v);
            total++; if (v !== 32'hB0 + 32'(i)) begin bad++; $display("FAIL rx_order[%0d] got=%h exp=%h", i, v, 32'hB0 + 32'(i)); end
        end
        peek(32'h0000_0808, v);
        total++; if (v !== 32'h0000_000A) begin bad++; $display("FAIL rx_drained got=%h exp=0000000a", v); end
    endtask

    task automatic test_wrap_underflow();
        logic [31:0] v;
        rx_data = 32'hD0; rx_valid = 1'b1;
        tick();
        // Host push and CPU pop in the same cycle, ten words through depth 4.
        for (int i = 1; i < 10; i++) begin
            rx_data = 32'hD0 + 32'(i);
            addr = 32'h0000_0804; re = 1'b1;
            #1;
            total++; if (rd !== 32'hD0 + 32'(i - 1)) begin bad++; $display("FAIL rx_wrap[%0d] got=%h exp=%h", i - 1, rd, 32'hD0 + 32'(i - 1)); end
            tick();
        end
        rx_valid = 1'b0; re = 1'b0;
        peek(32'h0000_0808, v);
        total++; if (v !== 32'h0001_0002) begin bad++; $display("FAIL rx_wrap_count got=%h exp=00010002", v); end
        cpu_read(32'h0000_0804, v);
        total++; if (v !== 32'hD9) begin bad++; $display("FAIL rx_wrap_last got=%h exp=000000d9", v); end
        cpu_read(32'h0000_0804, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL rx_udf_data got=%h exp=00000000", v); end
        peek(32'h0000_0808, v);
        total++; if (v !== 32'h0000_002A) begin bad++; $display("FAIL rx_udf_status got=%h exp=0000002a", v); end
        cpu_write(32'h0000_0808, 32'h20);
        peek(32'h0000_0808, v);
        total++; if (v !== 32'h0000_000A) begin bad++; $display("FAIL rx_udf_w1c got=%h exp=0000000a", v); end
    endtask

    task automatic test_irq();
        logic [31:0] v;
`ifdef MBOX_IRQ_EN
        cpu_write(32'h0000_080C, 32'h1);
        peek(32'h0000_080C, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL ctrl_rw got=%h exp=00000001", v); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
        rx_data = 32'hC0; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
        tick();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", irq); end
        cpu_read(32'h0000_0804, v);
        total++; if (v !== 32'hC0 || irq !== 1'b1) begin bad++; $display("FAIL irq_pop rd=%h irq=%b exp rd=000000c0 irq=1", v, irq); end
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
        cpu_write(32'h0000_080C, 32'h0);
`else
        cpu_write(32'h0000_080C, 32'h7);
        peek(32'h0000_080C, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL ctrl_ro got=%h exp=00000000", v); end
        rx_data = 32'hC0; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_tied got=%b exp=0", irq); end
        cpu_read(32'h0000_0804, v);
        total++; if (v !== 32'hC0) begin bad++; $display("FAIL irq_rxdata got=%h exp=000000c0", v); end
`endif
    endtask

    initial begin
        rst = 1'b0; addr = 32'h0; wd = 32'h0; we = 1'b0; re = 1'b0;
        tx_ready = 1'b0; rx_data = 32'h0; rx_valid = 1'b0;
        test_reset();
        test_decode();
        test_tx_stream();
        test_tx_overflow();
        test_rx_backpressure();
        test_wrap_underflow();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
